// File: rtl/madd_dot_seq.sv
// Dot-product sequencer around a single 8b x 8b multiply-add datapath.
// Operand pairs stream in one per cycle; the accumulated 16-bit sum, the
// element count and a sticky wrap flag are handed out once per vector.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The sender holds its payload stable while valid is high and not yet
// accepted; ready may depend on state and reset but never on valid.

module madd_dot_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf,
  output logic [1:0]       dbg_state   // current FSM state for observation
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               in_xfer;
  logic               out_xfer;
  logic [15:0]        prod;
  logic [16:0]        sum17;

  // Handshake qualifiers; in_rdy is held low while reset is asserted.
  always_comb begin
    in_rdy   = reset && (state_q != DONE);
    out_val  = (state_q == DONE);
    in_xfer  = in_val && in_rdy;
    out_xfer = out_val && out_rdy;
  end

  // Multiply-add datapath: 16-bit product plus accumulator, carry kept.
  always_comb begin
    prod  = {8'd0, in_a} * {8'd0, in_b};
    sum17 = {1'b0, acc_q} + {1'b0, prod};
  end

  // Next-state and register update logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, ACC: begin
        if (in_xfer) begin
          acc_d = sum17[15:0];
          ovf_d = ovf_q | sum17[16];
          // Count saturates at all-ones rather than wrapping.
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          state_d = in_last ? DONE : ACC;
        end
      end
      DONE: begin
        // Result held until the consumer takes it; inputs ignored here.
        if (out_xfer) begin
          acc_d   = 16'd0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= 16'd0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result outputs mirror the internal registers in every state.
  always_comb begin
    out_sum   = acc_q;
    out_cnt   = cnt_q;
    out_ovf   = ovf_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_madd_dot_seq.sv
// Directed bench for madd_dot_seq. Two instances share all stimulus: the
// default counter width and a 2-bit counter for the saturation case.

module tb_madd_dot_seq;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        out_val;
  logic        out_rdy;
  logic [15:0] out_sum;
  logic [7:0]  out_cnt;
  logic        out_ovf;
  logic [1:0]  dbg_state;

  logic        in_rdy2;
  logic        out_val2;
  logic [15:0] out_sum2;
  logic [1:0]  out_cnt2;
  logic        out_ovf2;
  logic [1:0]  dbg_state2;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  madd_dot_seq #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_val(out_val), .out_rdy(out_rdy),
    .out_sum(out_sum), .out_cnt(out_cnt), .out_ovf(out_ovf),
    .dbg_state(dbg_state)
  );

  madd_dot_seq #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy2),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_val(out_val2), .out_rdy(out_rdy),
    .out_sum(out_sum2), .out_cnt(out_cnt2), .out_ovf(out_ovf2),
    .dbg_state(dbg_state2)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven and outputs
  // sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Present one pair for exactly one cycle (in_rdy is known high here).
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    in_val  = 1'b1;
    in_a    = a;
    in_b    = b;
    in_last = last;
    step();
    in_val  = 1'b0;
    in_a    = $urandom_range(0, 255);
    in_b    = $urandom_range(0, 255);
    in_last = 1'b0;
  endtask

  // Scoreboard pop: compare the presented sum, then complete the handshake.
  task automatic take_result(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=result expected=empty_queue", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(out_sum), 32'(e));
    end
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    in_val  = 1'b0;
    in_a    = 8'd0;
    in_b    = 8'd0;
    in_last = 1'b0;
    out_rdy = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_out_val", 32'(out_val), 0);
    chk("rst_in_rdy",  32'(in_rdy), 0);
    chk("rst_sum",     32'(out_sum), 0);
    chk("rst_cnt",     32'(out_cnt), 0);
    chk("rst_ovf",     32'(out_ovf), 0);
    chk("rst_state",   32'(dbg_state), 32'(S_IDLE));
    reset = 1'b1;
    #1;
    chk("rel_in_rdy", 32'(in_rdy), 1);
    step();

    // Single pair 3*4
    send(8'd3, 8'd4, 1'b1);
    exp_q.push_back(16'd12);
    chk("t1_out_val", 32'(out_val), 1);
    chk("t1_cnt",     32'(out_cnt), 1);
    chk("t1_ovf",     32'(out_ovf), 0);
    chk("t1_in_rdy",  32'(in_rdy), 0);
    take_result("t1_sum");
    chk("t1_post_in_rdy", 32'(in_rdy), 1);
    chk("t1_post_state",  32'(dbg_state), 32'(S_IDLE));
    chk("t1_post_val",    32'(out_val), 0);
    chk("t1_post_sum",    32'(out_sum), 0);

    // Wrap: 2 * 65025 = 130050 -> 64514 with overflow
    send(8'd255, 8'd255, 1'b0);
    chk("t2_mid_state", 32'(dbg_state), 32'(S_ACC));
    chk("t2_mid_sum",   32'(out_sum), 65025);
    chk("t2_mid_ovf",   32'(out_ovf), 0);
    send(8'd255, 8'd255, 1'b1);
    exp_q.push_back(16'd64514);
    chk("t2_out_val", 32'(out_val), 1);
    chk("t2_cnt",     32'(out_cnt), 2);
    chk("t2_ovf",     32'(out_ovf), 1);
    take_result("t2_sum");
    send(8'd1, 8'd1, 1'b1);
    exp_q.push_back(16'd1);
    chk("t2b_ovf", 32'(out_ovf), 0);
    chk("t2b_cnt", 32'(out_cnt), 1);
    take_result("t2b_sum");

    // Gap mid-vector and backpressure
    send(8'd2, 8'd5, 1'b0);
    step();
    chk("t3_gap_sum",   32'(out_sum), 10);
    chk("t3_gap_state", 32'(dbg_state), 32'(S_ACC));
    send(8'd10, 8'd10, 1'b1);
    exp_q.push_back(16'd110);
    in_val  = 1'b1;
    in_a    = 8'd9;
    in_b    = 8'd9;
    in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold_val",   32'(out_val), 1);
      chk("t3_hold_sum",   32'(out_sum), 110);
      chk("t3_hold_cnt",   32'(out_cnt), 2);
      chk("t3_hold_ovf",   32'(out_ovf), 0);
      chk("t3_hold_in_rdy", 32'(in_rdy), 0);
    end
    in_val  = 1'b0;
    in_last = 1'b0;
    take_result("t3_sum");

    // Saturation: five 1*1 pairs
    for (int i = 0; i < 5; i++) begin
      send(8'd1, 8'd1, (i == 4));
    end
    exp_q.push_back(16'd5);
    chk("t4_sat_cnt2", 32'(out_cnt2), 3);
    chk("t4_sat_sum2", 32'(out_sum2), 5);
    chk("t4_sat_ovf2", 32'(out_ovf2), 0);
    chk("t4_sat_val2", 32'(out_val2), 1);
    chk("t4_cnt",      32'(out_cnt), 5);
    take_result("t4_sum");

    // Reset mid-vector
    send(8'd7, 8'd8, 1'b0);
    chk("t5_mid_sum", 32'(out_sum), 56);
    reset = 1'b0;
    #1;
    chk("t5_rst_sum",    32'(out_sum), 0);
    chk("t5_rst_cnt",    32'(out_cnt), 0);
    chk("t5_rst_state",  32'(dbg_state), 32'(S_IDLE));
    chk("t5_rst_in_rdy", 32'(in_rdy), 0);
    step();
    reset = 1'b1;
    #1;
    send(8'd1, 8'd2, 1'b1);
    exp_q.push_back(16'd2);
    chk("t5_cnt", 32'(out_cnt), 1);
    chk("t5_val", 32'(out_val), 1);
    take_result("t5_sum");

    // Reset while a result is pending
    send(8'd3, 8'd4, 1'b1);
    chk("t6_val_before", 32'(out_val), 1);
    chk("t6_sum_before", 32'(out_sum), 12);
    reset = 1'b0;
    #1;
    chk("t6_val_rst", 32'(out_val), 0);
    chk("t6_sum_rst", 32'(out_sum), 0);
    step();
    reset = 1'b1;
    #1;
    chk("t6_in_rdy", 32'(in_rdy), 1);
    step();
    chk("t6_val_after", 32'(out_val), 0);
    chk("t6_state",     32'(dbg_state), 32'(S_IDLE));
    chk("t6_queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
